// File: rtl/oam_ctrl_if.sv
// Bus bundle between the CPU/PPU side and the OAM controller.
// master: the controller itself; slave: the surrounding bus, PPU and OAM RAM.
interface oam_ctrl_if;
  // CPU register/bus side
  logic [7:0]  cpu_wdata;
  logic        oamaddr_we;
  logic        oamdata_we;
  logic        dma_we;
  // PPU side
  logic        rendering;
  logic [7:0]  se_oamaddr;
  // DMA bus master
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        cpu_halt;
  logic        dma_busy;
  // OAM RAM port
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  modport master (
    input  cpu_wdata,
    input  oamaddr_we,
    input  oamdata_we,
    input  dma_we,
    input  rendering,
    input  se_oamaddr,
    input  dma_rdata,
    output dma_rd,
    output dma_addr,
    output cpu_halt,
    output dma_busy,
    output oam_addr,
    output oam_wdata,
    output oam_we
  );

  modport slave (
    output cpu_wdata,
    output oamaddr_we,
    output oamdata_we,
    output dma_we,
    output rendering,
    output se_oamaddr,
    output dma_rdata,
    input  dma_rd,
    input  dma_addr,
    input  cpu_halt,
    input  dma_busy,
    input  oam_addr,
    input  oam_wdata,
    input  oam_we
  );
endinterface

// File: rtl/oam_ctrl.sv
// OAM port arbiter: shares the single primary-OAM port between CPU $2003/$2004
// accesses, the $4014 sprite DMA engine and sprite-evaluation reads.
module oam_ctrl #(
  parameter int unsigned DMA_ALIGN = 1,
  parameter int unsigned DMA_LEN   = 256
) (
  input  logic       clock,
  input  logic       reset,
  oam_ctrl_if.master bus
);

  // Counter wraps at 8 bits, so the terminal count is taken modulo 256.
  localparam logic [7:0] LastCnt   = 8'(DMA_LEN - 1);
  localparam logic [7:0] AlignLast = 8'(DMA_ALIGN - 1);
  localparam bit         NoAlign   = (DMA_ALIGN == 0);

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRd,
    StWr
  } dma_state_e;

  dma_state_e state_q, state_d;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] page_q, page_d;
  logic [7:0] align_q, align_d;
  logic [7:0] oamaddr_q, oamaddr_d;
  logic       pend_we_q, pend_we_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       busy_q, busy_d;

  logic       idle;
  logic       cpu_data_ok;
  logic       render_glitch;
  logic [7:0] incr_pend;
  logic [7:0] incr_glitch;

  assign idle = (state_q == StIdle);

  // $2004 is only honoured while the DMA engine is idle and $2003 is not also strobed.
  assign cpu_data_ok   = bus.oamdata_we && !bus.oamaddr_we && idle;
  // Writing $2004 during rendering skips ahead by one sprite instead of writing.
  assign render_glitch = cpu_data_ok && bus.rendering;
  assign incr_pend     = pend_we_q ? 8'd1 : 8'd0;
  assign incr_glitch   = render_glitch ? 8'd4 : 8'd0;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // DMA sequencing registers (counter, page, alignment delay)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      page_q  <= 8'd0;
      align_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      align_q <= align_d;
      busy_q  <= busy_d;
    end
  end

  // CPU-side registers: OAMADDR and the one-cycle pending $2004 write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oamaddr_q   <= 8'd0;
      pend_we_q   <= 1'b0;
      pend_data_q <= 8'd0;
    end else begin
      oamaddr_q   <= oamaddr_d;
      pend_we_q   <= pend_we_d;
      pend_data_q <= pend_data_d;
    end
  end

  // FSM next-state and DMA counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    align_d = align_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dma_we) begin
          page_d  = bus.cpu_wdata;
          cnt_d   = 8'd0;
          align_d = 8'd0;
          state_d = NoAlign ? StRd : StAlign;
        end
      end
      StAlign: begin
        if (align_q == AlignLast) begin
          state_d = StRd;
        end else begin
          align_d = align_q + 8'd1;
        end
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StRd;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Halt is registered so it tracks the state register exactly.
    busy_d = (state_d != StIdle);
  end

  // CPU-side next state: OAMADDR updates and pending data capture
  always_comb begin
    // Without an alignment gap the pending write would collide with the first DMA read.
    pend_we_d   = cpu_data_ok && !bus.rendering && !(bus.dma_we && NoAlign);
    pend_data_d = pend_we_d ? bus.cpu_wdata : pend_data_q;
    if (bus.oamaddr_we) begin
      oamaddr_d = bus.cpu_wdata;
    end else begin
      oamaddr_d = oamaddr_q + incr_pend + incr_glitch;
    end
  end

  // FSM outputs and OAM port mux (DMA write > pending CPU write > read address)
  always_comb begin
    bus.dma_rd    = 1'b0;
    bus.dma_addr  = 16'h0000;
    bus.oam_we    = 1'b0;
    bus.oam_wdata = 8'h00;
    bus.oam_addr  = bus.rendering ? bus.se_oamaddr : oamaddr_q;
    bus.cpu_halt  = busy_q;
    bus.dma_busy  = busy_q;
    if (state_q == StRd) begin
      bus.dma_rd   = 1'b1;
      bus.dma_addr = {page_q, cnt_q};
    end
    if (state_q == StWr) begin
      // Overrides se_oamaddr even while rendering; the sprite engine sees the DMA slot.
      bus.oam_we    = 1'b1;
      bus.oam_addr  = oamaddr_q + cnt_q;
      bus.oam_wdata = bus.dma_rdata;
    end else if (pend_we_q) begin
      bus.oam_we    = 1'b1;
      bus.oam_addr  = oamaddr_q;
      bus.oam_wdata = pend_data_q;
    end
  end

  // Port sharing invariants
  a_rd_we_excl : assert property (@(posedge clock) disable iff (reset)
    !(bus.dma_rd && bus.oam_we));
  a_pend_idle : assert property (@(posedge clock) disable iff (reset)
    pend_we_q |-> (state_q != StWr));
  a_halt_busy : assert property (@(posedge clock) disable iff (reset)
    busy_q == (state_q != StIdle));

endmodule

// File: tb/tb_oam_ctrl.sv
// Randomised bench for oam_ctrl against a byte-array model of OAM and OAMADDR.
module tb_oam_ctrl;

  localparam int unsigned DmaAlign = 1;
  localparam int unsigned DmaLen   = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;

  oam_ctrl_if bus ();

  oam_ctrl #(
    .DMA_ALIGN(DmaAlign),
    .DMA_LEN  (DmaLen)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // OAM RAM and source-bus model
  logic [7:0] mem [256] = '{default: 8'h00};
  int         wr_count  = 0;
  logic [7:0] src_key   = 8'h5A;

  always @(posedge clock) begin
    if (bus.oam_we) begin
      mem[bus.oam_addr] <= bus.oam_wdata;
      wr_count <= wr_count + 1;
    end
  end

  always @(posedge clock) begin
    bus.dma_rdata <= bus.dma_rd ? (bus.dma_addr[7:0] ^ src_key) : 8'h00;
  end

  // Every DMA read must walk the started page in order.
  logic [7:0] mon_page = 8'h00;
  logic [7:0] mon_idx  = 8'h00;

  always @(negedge clock) begin
    if (!reset) begin
      check_eq("rd_we_excl", 32'(bus.dma_rd & bus.oam_we), 32'd0);
    end
    if (!bus.dma_busy) begin
      mon_idx <= 8'h00;
    end else if (bus.dma_rd) begin
      check_eq("dma_addr", 32'(bus.dma_addr), 32'({mon_page, mon_idx}));
      mon_idx <= mon_idx + 8'd1;
    end
  end

  // Reference model: expected OAM contents and OAMADDR
  logic [7:0] exp_oam [256] = '{default: 8'h00};
  logic [7:0] exp_addr = 8'h00;

  task automatic model_cpu(input bit a_we, input bit d_we, input logic [7:0] d, input bit rend);
    if (a_we) begin
      exp_addr = d;
    end else if (d_we) begin
      if (rend) begin
        exp_addr = exp_addr + 8'd4;
      end else begin
        exp_oam[exp_addr] = d;
        exp_addr = exp_addr + 8'd1;
      end
    end
  endtask

  task automatic model_dma(input int unsigned nbytes);
    for (int i = 0; i < int'(nbytes); i++) begin
      exp_oam[8'(int'(exp_addr) + i)] = 8'(i) ^ src_key;
    end
  endtask

  task automatic compare_oam(input string tag);
    for (int i = 0; i < 256; i++) begin
      check_eq($sformatf("%s[%02h]", tag, i), 32'(mem[i]), 32'(exp_oam[i]));
    end
  endtask

  task automatic cpu_op(input bit a_we, input bit d_we, input logic [7:0] d, input bit rend);
    @(negedge clock);
    bus.cpu_wdata  = d;
    bus.oamaddr_we = a_we;
    bus.oamdata_we = d_we;
    bus.rendering  = rend;
    @(negedge clock);
    bus.oamaddr_we = 1'b0;
    bus.oamdata_we = 1'b0;
    bus.rendering  = 1'b0;
    @(negedge clock);
    model_cpu(a_we, d_we, d, rend);
  endtask

  task automatic dma_start(input logic [7:0] page);
    @(negedge clock);
    mon_page       = page;
    bus.cpu_wdata  = page;
    bus.dma_we     = 1'b1;
    @(negedge clock);
    bus.dma_we     = 1'b0;
  endtask

  task automatic dma_wait(output int halt_cycles);
    halt_cycles = 0;
    while (bus.cpu_halt && halt_cycles < 2000) begin
      halt_cycles++;
      @(negedge clock);
    end
    if (halt_cycles >= 2000) check_eq("dma_timeout", 32'(halt_cycles), 32'd0);
  endtask

  task automatic wait_dma_rd(input logic [7:0] idx, input string tag);
    int g;
    g = 0;
    while (!(bus.dma_rd && bus.dma_addr[7:0] == idx) && g < 2000) begin
      @(negedge clock);
      g++;
    end
    check_eq(tag, 32'(g < 2000), 32'd1);
  endtask

  initial begin
    int  n;
    int  w0;
    int  kind;
    bit  a_we;
    bit  d_we;
    bit  rend;
    logic [7:0] d;

    bus.cpu_wdata  = 8'h00;
    bus.oamaddr_we = 1'b0;
    bus.oamdata_we = 1'b0;
    bus.dma_we     = 1'b0;
    bus.rendering  = 1'b0;
    bus.se_oamaddr = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_dma_rd",   32'(bus.dma_rd),    32'd0);
    check_eq("rst_dma_addr", 32'(bus.dma_addr),  32'd0);
    check_eq("rst_cpu_halt", 32'(bus.cpu_halt),  32'd0);
    check_eq("rst_dma_busy", 32'(bus.dma_busy),  32'd0);
    check_eq("rst_oam_we",   32'(bus.oam_we),    32'd0);
    check_eq("rst_oam_addr", 32'(bus.oam_addr),  32'd0);
    check_eq("rst_oam_wd",   32'(bus.oam_wdata), 32'd0);

    // CPU writes wrapping past 0xFF
    cpu_op(1'b1, 1'b0, 8'hFE, 1'b0);
    cpu_op(1'b0, 1'b1, 8'hAA, 1'b0);
    cpu_op(1'b0, 1'b1, 8'hBB, 1'b0);
    cpu_op(1'b0, 1'b1, 8'hCC, 1'b0);
    check_eq("cpu_oam_fe", 32'(mem[8'hFE]), 32'h0AA);
    check_eq("cpu_oam_ff", 32'(mem[8'hFF]), 32'h0BB);
    check_eq("cpu_oam_00", 32'(mem[8'h00]), 32'h0CC);
    check_eq("cpu_oamaddr", 32'(bus.oam_addr), 32'h01);

    // Full DMA from page 2 into OAMADDR 0, halt length measured
    cpu_op(1'b1, 1'b0, 8'h00, 1'b0);
    src_key = 8'h5A;
    dma_start(8'h02);
    dma_wait(n);
    check_eq("halt_cycles", 32'(n), 32'(1 + DmaAlign + 2 * DmaLen - 1));
    model_dma(DmaLen);
    compare_oam("dma_p2");
    check_eq("dma_p2_oamaddr", 32'(bus.oam_addr), 32'(exp_addr));

    // DMA rotated by OAMADDR 0x10
    cpu_op(1'b1, 1'b0, 8'h10, 1'b0);
    src_key = 8'($urandom);
    dma_start(8'h03);
    dma_wait(n);
    model_dma(DmaLen);
    compare_oam("dma_p3");
    check_eq("dma_p3_oamaddr", 32'(bus.oam_addr), 32'h10);

    // Rendering: address follows sprite engine, $2004 only bumps OAMADDR by 4
    w0 = wr_count;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      bus.rendering  = 1'b1;
      bus.se_oamaddr = 8'(i);
      bus.oamdata_we = (i == 40 || i == 90);
      bus.cpu_wdata  = 8'($urandom);
      #1;
      check_eq("se_follow", 32'(bus.oam_addr), 32'(i));
    end
    @(negedge clock);
    bus.oamdata_we = 1'b0;
    bus.rendering  = 1'b0;
    exp_addr = exp_addr + 8'd8;
    #1;
    check_eq("render_no_we", 32'(wr_count - w0), 32'd0);
    check_eq("render_oamaddr", 32'(bus.oam_addr), 32'(exp_addr));

    // Random CPU register traffic
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 3));
      a_we = (kind == 0 || kind == 3);
      d_we = (kind != 0);
      d    = 8'($urandom);
      rend = 1'($urandom_range(0, 1));
      cpu_op(a_we, d_we, d, rend);
      check_eq("rand_oamaddr", 32'(bus.oam_addr), 32'(exp_addr));
    end
    compare_oam("rand_cpu");

    // Second $4014 and $2004 during a transfer are ignored
    cpu_op(1'b1, 1'b0, 8'($urandom), 1'b0);
    src_key = 8'($urandom);
    dma_start(8'h04);
    wait_dma_rd(8'h40, "inj_reach");
    bus.cpu_wdata = 8'h09;
    bus.dma_we    = 1'b1;
    @(negedge clock);
    bus.dma_we     = 1'b0;
    bus.cpu_wdata  = 8'hEE;
    bus.oamdata_we = 1'b1;
    @(negedge clock);
    bus.oamdata_we = 1'b0;
    dma_wait(n);
    model_dma(DmaLen);
    compare_oam("dma_inj");
    check_eq("inj_oamaddr", 32'(bus.oam_addr), 32'(exp_addr));

    // Reset in the middle of a transfer
    cpu_op(1'b1, 1'b0, 8'h00, 1'b0);
    src_key = 8'($urandom);
    dma_start(8'h05);
    wait_dma_rd(8'h80, "abort_reach");
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_halt", 32'(bus.cpu_halt), 32'd0);
    check_eq("abort_busy", 32'(bus.dma_busy), 32'd0);
    check_eq("abort_rd",   32'(bus.dma_rd),   32'd0);
    model_dma(32'h80);
    exp_addr = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    w0 = wr_count;
    repeat (20) @(negedge clock);
    check_eq("abort_no_wr", 32'(wr_count - w0), 32'd0);
    compare_oam("dma_abort");
    check_eq("abort_oamaddr", 32'(bus.oam_addr), 32'(exp_addr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
